// File: rtl/montgomery_redc.sv
// -----------------------------------------------------------------------------
// montgomery_redc
//   Bit-serial radix-2 Montgomery reduction (REDC).
//   result = T * 2^-N mod M, fully reduced to [0, M).
//
//   Sequence: IDLE --start--> ITER (N cycles) -> SUB -> DONE -> IDLE/ITER
//   A start is accepted in IDLE or DONE, so operations may run back to back.
//   A start seen in any other state is ignored.
//
//   Optional build macro: MONT_REDC_RANGE_CHK_EN
//     When defined, a request with an even or zero modulus, or with
//     t_in >= (m_in << N), skips ITER/SUB. It goes to DONE on the next cycle
//     with err=1 and result=0. When undefined, err is constant 0 and every
//     request runs the full sequence.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   start   in   request strobe
//   t_in    in   [2N-1:0] value to reduce (T < 2^N * M)
//   m_in    in   [N-1:0]  odd modulus
//   busy    out  high in ITER/SUB/DONE
//   done    out  one-cycle pulse, result valid
//   result  out  [N-1:0] reduced value, held until the next accepted start
//   err     out  range-check failure flag
// -----------------------------------------------------------------------------
module montgomery_redc #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] t_in,
  input  logic [N-1:0]   m_in,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result,
  output logic           err
);

  localparam int AW = 2*N + 1;          // one guard bit so acc + m never overflows
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, SUB, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   acc_sum;
  logic [N-1:0]    m_q;
  logic [CW-1:0]   count;
  logic            accept;
  logic            bad_req;
  logic            last_iter;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (count == CW'(N - 1));
  assign m_ext     = {{(N+1){1'b0}}, m_q};
  // Add M only when acc is odd, so the sum is always even and the shift is exact.
  assign acc_sum   = acc + (acc[0] ? m_ext : '0);

`ifdef MONT_REDC_RANGE_CHK_EN
  assign bad_req = (m_in[0] == 1'b0) || (m_in == '0) ||
                   (t_in >= {m_in, {N{1'b0}}});
`else
  assign bad_req = 1'b0;
`endif

  // NOTE: next state gets its default before any branch; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = bad_req ? DONE : ITER;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        ITER:    if (last_iter) state_nxt = SUB;
        SUB:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignment. Every register
  // updates from values sampled at the same edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      m_q    <= '0;
      count  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= {1'b0, t_in};
        m_q   <= m_in;
        count <= '0;
        if (bad_req) begin
          result <= '0;
          err    <= 1'b1;
        end
      end else begin
        unique case (state)
          ITER: begin
            acc   <= acc_sum >> 1;
            count <= count + CW'(1);
          end
          SUB: begin
            // acc < 2M here, so one conditional subtraction fully reduces it.
            // The difference is below M, so the low N bits are exact.
            if (acc >= m_ext) result <= acc[N-1:0] - m_q;
            else              result <= acc[N-1:0];
            err <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_montgomery_redc.sv
module tb_montgomery_redc;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] t_in;
  logic [N-1:0]   m_in;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;
  logic           err;

  int checks = 0;
  int errors = 0;

  montgomery_redc #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .t_in   (t_in),
    .m_in   (m_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the unique r in [0,M) with r * 2^N == T (mod M).
  function automatic int redc_ref(input int t, input int m);
    for (int r = 0; r < m; r++)
      if (((r << N) % m) == (t % m)) return r;
    return -1;
  endfunction

  // Issue one request and count rising edges from the start-sampling edge
  // until done is seen. lat counts the start cycle as cycle 0. When wait_first
  // is 0, the request is driven at the current time (used inside a DONE cycle).
  // When poke is 1, a stray start with junk operands is driven during ITER.
  task automatic do_op(input int t, input int m, input bit wait_first,
                       input bit poke, output int lat);
    if (wait_first) @(negedge clk);
    t_in  = t[2*N-1:0];
    m_in  = m[N-1:0];
    start = 1'b1;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (poke && lat == 3) begin
        start = 1'b1;
        t_in  = 12'($urandom);
        m_in  = 6'($urandom);
      end else begin
        start = 1'b0;
      end
      check("busy_during_op", busy, 1);
    end while (!done && lat < 40);
    check("done_seen", done, 1);
  endtask

  int lat;
  int m_r, t_r;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    t_in  = '0;
    m_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Basic: 448 = 7 * 64.
    do_op(448, 53, 1, 0, lat);
    check("lat_448", lat, N + 2);
    check("res_448", result, 7);
    check("err_448", err, 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("res_held", result, 7);

    do_op(1, 53, 1, 0, lat);
    check("res_t1", result, 29);
    do_op(0, 53, 1, 0, lat);
    check("res_t0", result, 0);
    do_op(3391, 53, 1, 0, lat);
    check("res_tmax", result, 24);
    check("lat_tmax", lat, N + 2);

    // Back-to-back: the second start is driven during the DONE cycle.
    do_op(100, 53, 1, 0, lat);
    check("res_b2b_first", result, redc_ref(100, 53));
    do_op(448, 53, 0, 0, lat);
    check("lat_b2b", lat, N + 2);
    check("res_b2b", result, 7);

    // A start during ITER is ignored.
    do_op(3391, 53, 1, 1, lat);
    check("lat_poke", lat, N + 2);
    check("res_poke", result, 24);

    // Reset during ITER cycle 3.
    @(negedge clk);
    t_in = 12'd448; m_in = 6'd53; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      if (i == 3) rst = 1'b0;
    end
    do_op(448, 53, 1, 0, lat);
    check("post_abort_res", result, 7);
    check("post_abort_lat", lat, N + 2);

`ifdef MONT_REDC_RANGE_CHK_EN
    do_op(448, 52, 1, 0, lat);
    check("chk_even_lat", lat, 1);
    check("chk_even_err", err, 1);
    check("chk_even_res", result, 0);
    do_op(3392, 53, 1, 0, lat);
    check("chk_big_lat", lat, 1);
    check("chk_big_err", err, 1);
    do_op(448, 53, 1, 0, lat);
    check("chk_clear_err", err, 0);
    check("chk_clear_res", result, 7);
`else
    do_op(448, 52, 1, 0, lat);
    check("nochk_even_lat", lat, N + 2);
    check("nochk_even_err", err, 0);
`endif

    // Randomized valid requests against the reference.
    for (int i = 0; i < 60; i++) begin
      m_r = 2 * $urandom_range(1, 31) + 1;
      t_r = $urandom_range(0, m_r * 64 - 1);
      do_op(t_r, m_r, ($urandom_range(0, 1) == 1), 0, lat);
      check("rnd_res", result, redc_ref(t_r, m_r));
      check("rnd_lat", lat, N + 2);
      check("rnd_err", err, 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
